param_arith_unit: RTL and testbench
===================================

# param_arith_unit

Parametrised, W-bit signed arithmetic unit: the multi-cycle successor of the 8-bit add/sub/mul/div datapath. Add and subtract complete in one registered cycle. Multiply uses a radix-2 Booth sequencer and divide uses a restoring sequencer over an accumulator/quotient/multiplicand register set, both under a start/done handshake. It sits behind the instruction decoder as the shared arithmetic resource of the ALU.

## Interface
- `W`, default 8: operand width in bits, W ≥ 4; the result is 2W bits.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request. Sampled only in IDLE.
- `op` in 2: operation select; 00 add, 01 sub, 10 mul, 11 div.
- `x` in W: signed operand (dividend for div). Sampled at the accepting edge only.
- `y` in W: signed operand (divisor for div). Sampled at the accepting edge only.
- `z` out 2W: result register.
- `busy` out 1: high while a mul/div is in flight.
- `done` out 1: one-cycle pulse; `z`, `err` and `ovf` are valid with it.
- `err` out 1: divide by zero, or op=11 when divide is compiled out.
- `ovf` out 1: divide quotient overflow.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1, op=0x: z ← sign-extended (W+1)-bit x±y; done=1; stay in IDLE.
- IDLE, start=1, op=10: load A=0, Q=x, M=y, Q₋₁=0, count=0; go to CALC.
  - CALC runs one Booth step per cycle: add/sub M per {Q[0],Q₋₁}, then arithmetic right shift of {A,Q,Q₋₁}.
- IDLE, start=1, op=11, y≠0: load A=0, Q=|x|, M=|y|, and latch both signs; go to CALC.
  - CALC runs one restoring step per cycle: shift {A,Q} left, trial A−M, restore on a negative result, Q[0] ← ~sign.
- IDLE, start=1, op=11, y=0: z=0, err=1, done=1; no CALC.
- CALC → FIX when count reaches W−1, i.e. after W steps.
- FIX for mul: z ← {A,Q}.
- FIX for div:
  - Quotient is negated if the signs differ; remainder takes the dividend's sign, truncating toward zero. z ← {rem, quot}.
  - ovf=1 iff x=−2^(W−1) and y=−1. The quotient then wraps to −2^(W−1) and the remainder is 0.
- FIX always pulses done and returns to IDLE.
- start while busy is ignored; inputs are not re-sampled.
- `z` holds its last value until the next done.
- `err` and `ovf` update only with done and hold until the next done.
- Count width is $clog2(W).

## Timing
- Reset (async, rst=0): state IDLE; z=0, busy=0, done=0, err=0, ovf=0; A, Q, M and count cleared.
- Reset mid-operation aborts the operation, with no done pulse.
- Add/sub: done and z in the cycle after the accepting edge (latency 1).
- Mul/div: busy=1 from the accepting edge until the FIX edge.
  - done asserts after edge W+1 counted from the accepting edge (latency W+1). For W=8, that is 9 cycles.
- Divide by zero and unsupported ops: latency 1, busy stays 0.
- Back-to-back: start may be high in the same cycle as done, because the unit is in IDLE; it is accepted.
- done is never high for two consecutive cycles, except on back-to-back 1-cycle ops.

## Configuration
- `ARITH_DIV_EN` defined: the restoring divider, sign fixup and ovf logic are built as described.
- `ARITH_DIV_EN` undefined: op=11 completes in 1 cycle with z=0, err=1, ovf=0, busy never asserted.
  - No divider hardware is built, and ovf is tied to 0.

## Test plan
- W=8, add x=100, y=50 → z=16'h0096, done one cycle after start, err=0.
- Sub x=8'h80 (−128), y=1 → z=16'hFF7F (−129), latency 1.
- Mul x=8'hF9 (−7), y=13 → z=16'hFFA5 (−91), busy high for 9 cycles, done exactly 9 cycles after the accepting edge. A second start during busy is ignored.
- Div x=−100, y=7 → z=16'hFEF2 (rem −2, quot −14), done at 9 cycles.
- Div x=8'h80, y=8'hFF → z=16'h0080, ovf=1.
- Div y=0 → z=0, err=1, done after 1 cycle.
  - Repeat with `ARITH_DIV_EN` undefined: any op=11 → z=0, err=1.
- Mul started, rst driven low during cycle 4 → z=0, busy=0, no done.
  - After release, a new add x=1, y=1 → z=16'h0002.

Source files
------------

// File: rtl/param_arith_unit.sv
// param_arith_unit: W-bit signed add/sub in one cycle, Booth multiply and restoring divide in W+1 cycles.
// Define ARITH_DIV_EN to build the divider; without it op=11 completes at once with err=1.
module param_arith_unit #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] z,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           ovf
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  function automatic logic [W-1:0] neg_val(input logic [W-1:0] v);
    neg_val = ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
    abs_val = v[W-1] ? neg_val(v) : v;
  endfunction

  state_t          state_r, state_nx_s;
  logic [W:0]      a_r, a_nx_s, m_r, bsum_s, addsub_s;
  logic [W-1:0]    q_r, q_nx_s;
  logic            q1_r, q1_nx_s;
  logic [CW-1:0]   cnt_r;
  logic            go_calc_s;
  logic [2*W-1:0]  fix_z_s;
  logic            fix_ovf_s;
`ifdef ARITH_DIV_EN
  logic            div_r, sx_r, sy_r;
  logic [W:0]      ash_s, diff_s;
  logic [W-1:0]    quot_s, rem_s;
`endif

  // One extra bit keeps the add/sub result exact before sign extension to 2W.
  always_comb begin
    addsub_s = op[0] ? ({x[W-1], x} - {y[W-1], y}) : ({x[W-1], x} + {y[W-1], y});
  end

  // Requests that need the sequencer.
  always_comb begin
    go_calc_s = 1'b0;
    if (start && op == 2'b10) begin
      go_calc_s = 1'b1;
    end
`ifdef ARITH_DIV_EN
    else if (start && op == 2'b11 && y != {W{1'b0}}) begin
      go_calc_s = 1'b1;
    end
`endif
    else begin
      go_calc_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE:    if (go_calc_s) state_nx_s = CALC; else state_nx_s = IDLE;
      CALC:    if (cnt_r == CNT_LAST) state_nx_s = FIX; else state_nx_s = CALC;
      FIX:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // One sequencer step; A is W+1 bits so A-M cannot overflow when M is the most negative value.
  always_comb begin
    bsum_s = a_r;
    case ({q_r[0], q1_r})
      2'b01:   bsum_s = a_r + m_r;
      2'b10:   bsum_s = a_r - m_r;
      default: bsum_s = a_r;
    endcase
    a_nx_s  = {bsum_s[W], bsum_s[W:1]};
    q_nx_s  = {bsum_s[0], q_r[W-1:1]};
    q1_nx_s = q_r[0];
`ifdef ARITH_DIV_EN
    ash_s  = {a_r[W-1:0], q_r[W-1]};
    diff_s = ash_s - m_r;
    if (div_r) begin
      q1_nx_s = 1'b0;
      if (diff_s[W]) begin
        a_nx_s = ash_s;
        q_nx_s = {q_r[W-2:0], 1'b0};
      end else begin
        a_nx_s = diff_s;
        q_nx_s = {q_r[W-2:0], 1'b1};
      end
    end else begin
      q1_nx_s = q_r[0];
    end
`endif
  end

  // Final result formation; a quotient magnitude with its top bit set and equal signs is -2^(W-1) / -1.
  always_comb begin
    fix_z_s   = {a_r[W-1:0], q_r};
    fix_ovf_s = 1'b0;
`ifdef ARITH_DIV_EN
    quot_s = (sx_r ^ sy_r) ? neg_val(q_r) : q_r;
    rem_s  = sx_r ? neg_val(a_r[W-1:0]) : a_r[W-1:0];
    if (div_r) begin
      fix_z_s   = {rem_s, quot_s};
      fix_ovf_s = ~(sx_r ^ sy_r) & q_r[W-1];
    end else begin
      fix_z_s   = {a_r[W-1:0], q_r};
      fix_ovf_s = 1'b0;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nx_s;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r   <= {(W+1){1'b0}};
      m_r   <= {(W+1){1'b0}};
      q_r   <= {W{1'b0}};
      q1_r  <= 1'b0;
      cnt_r <= {CW{1'b0}};
      z     <= {(2*W){1'b0}};
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
`ifdef ARITH_DIV_EN
      div_r <= 1'b0;
      sx_r  <= 1'b0;
      sy_r  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            case (op)
              2'b00, 2'b01: begin
                z    <= {{(W-1){addsub_s[W]}}, addsub_s};
                err  <= 1'b0;
                ovf  <= 1'b0;
                done <= 1'b1;
              end
              2'b10: begin
                a_r   <= {(W+1){1'b0}};
                q_r   <= x;
                m_r   <= {y[W-1], y};
                q1_r  <= 1'b0;
                cnt_r <= {CW{1'b0}};
                busy  <= 1'b1;
`ifdef ARITH_DIV_EN
                div_r <= 1'b0;
`endif
              end
              2'b11: begin
`ifdef ARITH_DIV_EN
                if (y == {W{1'b0}}) begin
                  z    <= {(2*W){1'b0}};
                  err  <= 1'b1;
                  ovf  <= 1'b0;
                  done <= 1'b1;
                end else begin
                  a_r   <= {(W+1){1'b0}};
                  q_r   <= abs_val(x);
                  m_r   <= {1'b0, abs_val(y)};
                  q1_r  <= 1'b0;
                  cnt_r <= {CW{1'b0}};
                  busy  <= 1'b1;
                  div_r <= 1'b1;
                  sx_r  <= x[W-1];
                  sy_r  <= y[W-1];
                end
`else
                z    <= {(2*W){1'b0}};
                err  <= 1'b1;
                ovf  <= 1'b0;
                done <= 1'b1;
`endif
              end
              default: begin
              end
            endcase
          end
        end
        CALC: begin
          a_r   <= a_nx_s;
          q_r   <= q_nx_s;
          q1_r  <= q1_nx_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          z    <= fix_z_s;
          err  <= 1'b0;
          ovf  <= fix_ovf_s;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_param_arith_unit.sv
// Directed bench for param_arith_unit (W=8); division expectations follow ARITH_DIV_EN.
module tb_param_arith_unit;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   x, y;
  logic [2*W-1:0] z;
  logic           busy, done, err, ovf;

  int checks = 0;
  int errors = 0;
  int dcount;

  typedef struct {
    logic [15:0] z;
    logic        err;
    logic        ovf;
    int          edges;
    int          nbusy;
    string       tag;
  } exp_t;

  exp_t sb[$];

  param_arith_unit #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .x(x), .y(y),
    .z(z), .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // edges: clock edges after the accepting edge until done is visible (0 for 1-cycle ops).
  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ez, input logic ee, input logic eo,
                        input int eedges, input int enbusy, input string tag);
    exp_t e, g;
    int edges, nbusy;
    e.z = ez; e.err = ee; e.ovf = eo; e.edges = eedges; e.nbusy = enbusy; e.tag = tag;
    sb.push_back(e);
    op = o; x = a; y = b; start = 1'b1;
    tick();
    start = 1'b0; op = 2'b00; x = 8'hA5; y = 8'h5A;
    edges = 0; nbusy = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) nbusy++;
      start = (edges == 3);
      tick();
      edges++;
    end
    start = 1'b0;
    g = sb.pop_front();
    chk({g.tag, "/done"}, done, 1);
    chk({g.tag, "/z"}, z, g.z);
    chk({g.tag, "/err"}, err, g.err);
    chk({g.tag, "/ovf"}, ovf, g.ovf);
    chk({g.tag, "/edges"}, edges, g.edges);
    chk({g.tag, "/busy_cycles"}, nbusy, g.nbusy);
    chk({g.tag, "/busy_at_done"}, busy, 0);
    tick();
    chk({g.tag, "/pulse"}, done, 0);
    chk({g.tag, "/z_hold"}, z, g.z);
    chk({g.tag, "/err_hold"}, err, g.err);
    chk({g.tag, "/ovf_hold"}, ovf, g.ovf);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; x = '0; y = '0;
    #12;
    chk("rst/z", z, 0);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/err", err, 0);
    chk("rst/ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b1;

    run_op(2'b00, 8'd100, 8'd50, 16'h0096, 1'b0, 1'b0, 0, 0, "add");
    run_op(2'b01, 8'h80, 8'h01, 16'hFF7F, 1'b0, 1'b0, 0, 0, "sub_min");
    run_op(2'b01, 8'h7F, 8'h80, 16'h00FF, 1'b0, 1'b0, 0, 0, "sub_max");
    run_op(2'b00, 8'hFF, 8'hFF, 16'hFFFE, 1'b0, 1'b0, 0, 0, "add_neg");
    run_op(2'b10, 8'hF9, 8'h0D, 16'hFFA5, 1'b0, 1'b0, 9, 9, "mul");
    run_op(2'b10, 8'h7F, 8'h80, 16'hC080, 1'b0, 1'b0, 9, 9, "mul_maxmin");
    run_op(2'b10, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, 9, 9, "mul_minmin");
`ifdef ARITH_DIV_EN
    run_op(2'b11, 8'h9C, 8'h07, 16'hFEF2, 1'b0, 1'b0, 9, 9, "div_neg");
    run_op(2'b11, 8'h80, 8'hFF, 16'h0080, 1'b0, 1'b1, 9, 9, "div_ovf");
    run_op(2'b11, 8'h07, 8'hFE, 16'h01FD, 1'b0, 1'b0, 9, 9, "div_negy");
    run_op(2'b11, 8'h9C, 8'h00, 16'h0000, 1'b1, 1'b0, 0, 0, "div_zero");
`else
    run_op(2'b11, 8'h9C, 8'h07, 16'h0000, 1'b1, 1'b0, 0, 0, "div_off");
    run_op(2'b11, 8'h9C, 8'h00, 16'h0000, 1'b1, 1'b0, 0, 0, "div_off_zero");
`endif
    run_op(2'b00, 8'h01, 8'h02, 16'h0003, 1'b0, 1'b0, 0, 0, "add_clear");

    // Back-to-back: start stays high in the cycle done is reported.
    op = 2'b00; x = 8'h03; y = 8'h04; start = 1'b1;
    tick();
    chk("b2b1/done", done, 1);
    chk("b2b1/z", z, 16'h0007);
    op = 2'b01; x = 8'h7F; y = 8'h80;
    tick();
    chk("b2b2/done", done, 1);
    chk("b2b2/z", z, 16'h00FF);
    start = 1'b0;
    tick();
    chk("b2b/pulse", done, 0);

    // Reset in the fourth cycle of a multiply aborts it silently.
    op = 2'b10; x = 8'hF9; y = 8'h0D; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("abort/z", z, 0);
    chk("abort/busy", busy, 0);
    chk("abort/done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    chk("abort/no_done", dcount, 0);
    chk("abort/busy_after", busy, 0);
    run_op(2'b00, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 0, 0, "add_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
